// File: rtl/shift_serializer_pkg.sv
// Shared definitions for the shift serializer: FSM state encodings
// (3-bit, IDLE=0, common with the shift receiver), default word width
// and a counter-width helper.
// Optional macro: SHIFT_SERIALIZER_PARITY_EN adds the PARITY state.
package shift_serializer_pkg;

    localparam int unsigned SER_NUM_W = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef SHIFT_SERIALIZER_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } state_t;

    // Width of a counter holding 0..n-1, never narrower than one bit
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shift_serializer_bit_timer.sv
// Bit period timer for the shift serializer. Counts 0..DIV-1 while
// enabled and pulses bit_end on the last cycle of every bit period.
// Held at zero while enable is low.
// Optional macro SHIFT_SERIALIZER_PARITY_EN has no effect here.
module shift_serializer_bit_timer
    import shift_serializer_pkg::*;
#(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    output logic bit_end
);

    localparam int unsigned CW = cnt_width(DIV);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last  = (r_cnt == CW'(DIV - 1));
    assign bit_end = enable && w_last;

    // Cycle counter within the current bit; wraps at DIV-1 or clears when idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (!enable || w_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/shift_serializer.sv
// Parallel-to-serial transmitter: captures a word on load and sends it
// MSB-first between a start bit (0) and a stop bit (1), each bit held
// DIV clocks. ledr mirrors the shift register contents.
// Optional macro: SHIFT_SERIALIZER_PARITY_EN inserts an even-parity bit
// between the data bits and the stop bit.
module shift_serializer
    import shift_serializer_pkg::*;
#(
    parameter int unsigned NUM_W = SER_NUM_W,
    parameter int unsigned DIV   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [NUM_W-1:0] data_in,
    output logic             ser_out,
    output logic             busy,
    output logic             done,
    output logic [NUM_W-1:0] ledr
);

    localparam int unsigned IW = cnt_width(NUM_W);

    state_t           r_state;
    state_t           w_state_next;
    logic [NUM_W-1:0] r_shreg;
    logic [NUM_W-1:0] w_shreg_next;
    logic [IW-1:0]    r_bit_idx;
    logic [IW-1:0]    w_bit_idx_next;
    logic             r_ser_out;
    logic             r_busy;
    logic             r_done;
    logic             w_ser_next;
    logic             w_busy_next;
    logic             w_done_next;
    logic             w_timer_en;
    logic             w_bit_end;
`ifdef SHIFT_SERIALIZER_PARITY_EN
    logic             r_parity;
    logic             w_parity_next;
`endif

    assign w_timer_en = (r_state != ST_IDLE);

    shift_serializer_bit_timer #(
        .DIV (DIV)
    ) u_bit_timer (
        .clk     (clk),
        .rst     (rst),
        .enable  (w_timer_en),
        .bit_end (w_bit_end)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state, shift register and bit index update
    always_comb begin
        w_state_next   = r_state;
        w_shreg_next   = r_shreg;
        w_bit_idx_next = r_bit_idx;
`ifdef SHIFT_SERIALIZER_PARITY_EN
        w_parity_next  = r_parity;
`endif
        case (r_state)
            ST_IDLE: begin
                if (load) begin
                    w_state_next = ST_START;
                    w_shreg_next = data_in;
`ifdef SHIFT_SERIALIZER_PARITY_EN
                    w_parity_next = ^data_in;
`endif
                end
            end
            ST_START: begin
                if (w_bit_end) begin
                    w_state_next   = ST_DATA;
                    w_bit_idx_next = IW'(NUM_W - 1);
                end
            end
            ST_DATA: begin
                if (w_bit_end) begin
                    w_shreg_next = r_shreg << 1;
                    if (r_bit_idx == '0) begin
`ifdef SHIFT_SERIALIZER_PARITY_EN
                        w_state_next = ST_PARITY;
`else
                        w_state_next = ST_STOP;
`endif
                    end else begin
                        w_bit_idx_next = r_bit_idx - 1'b1;
                    end
                end
            end
`ifdef SHIFT_SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (w_bit_end) begin
                    w_state_next = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (w_bit_end) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they describe
    always_comb begin
        w_busy_next = (w_state_next != ST_IDLE);
        w_done_next = (r_state == ST_STOP) && w_bit_end;
        case (w_state_next)
            ST_START:  w_ser_next = 1'b0;
            ST_DATA:   w_ser_next = w_shreg_next[NUM_W-1];
`ifdef SHIFT_SERIALIZER_PARITY_EN
            ST_PARITY: w_ser_next = w_parity_next;
`endif
            default:   w_ser_next = 1'b1;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_shreg   <= '0;
            r_bit_idx <= '0;
            r_ser_out <= 1'b1;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            r_parity  <= 1'b0;
`endif
        end else begin
            r_shreg   <= w_shreg_next;
            r_bit_idx <= w_bit_idx_next;
            r_ser_out <= w_ser_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
`ifdef SHIFT_SERIALIZER_PARITY_EN
            r_parity  <= w_parity_next;
`endif
        end
    end

    assign ser_out = r_ser_out;
    assign busy    = r_busy;
    assign done    = r_done;
    assign ledr    = r_shreg;

endmodule
